// File: rtl/traffic_pkg.sv
// Shared traffic-light types and default sizing.
// Used by the farm-road queue, release stage and controller.
package traffic_pkg;

  localparam int QUEUE_DEPTH = 15;
  localparam int TS_W        = 8;
  localparam int WAIT_LIMIT  = 20;
  localparam int SERVED_W    = 10;

  typedef logic [4:0]      count_t;
  typedef logic [TS_W-1:0] ts_t;

endpackage

// File: rtl/fr_car_queue_if.sv
// Farm-road queue bundle: arrival/departure events in,
// occupancy, wait and statistics out.
interface fr_car_queue_if #(
  parameter int TS_W     = traffic_pkg::TS_W,
  parameter int SERVED_W = traffic_pkg::SERVED_W
);
  import traffic_pkg::*;

  logic                car_arrive;
  logic                car_depart;
  logic                car_in_queue;
  count_t              car_count;
  logic                queue_full;
  logic [TS_W-1:0]     oldest_wait;
  logic                long_wait;
  logic                overflow;
  logic                underflow;
  logic [SERVED_W-1:0] cars_served;

  modport master (
    output car_arrive,
    output car_depart,
    input  car_in_queue,
    input  car_count,
    input  queue_full,
    input  oldest_wait,
    input  long_wait,
    input  overflow,
    input  underflow,
    input  cars_served
  );

  modport slave (
    input  car_arrive,
    input  car_depart,
    output car_in_queue,
    output car_count,
    output queue_full,
    output oldest_wait,
    output long_wait,
    output overflow,
    output underflow,
    output cars_served
  );

endinterface

// File: rtl/ts_fifo.sv
// Synchronous timestamp FIFO; head word is read combinationally.
// Callers must never push when full without a same-cycle pop.
module ts_fifo #(
  parameter int DEPTH = traffic_pkg::QUEUE_DEPTH,
  parameter int W     = traffic_pkg::TS_W
) (
  input  logic                  traffic_clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [W-1:0]          wdata,
  output logic [W-1:0]          head,
  output traffic_pkg::count_t   count
);
  import traffic_pkg::*;

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_nxt;
  logic [AW-1:0] rd_nxt;
  count_t        cnt;

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  always_comb begin
    wr_nxt = wr_ptr + AW'(1);
    rd_nxt = rd_ptr + AW'(1);
    if (wr_ptr == LAST) wr_nxt = '0;
    if (rd_ptr == LAST) rd_nxt = '0;
  end

  always_ff @(posedge traffic_clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_nxt;
      if (pop)  rd_ptr <= rd_nxt;
      unique case (1'b1)
        push && !pop: cnt <= cnt + 5'd1;
        pop && !push: cnt <= cnt - 5'd1;
        default:      cnt <= cnt;
      endcase
    end
  end

  // Storage is not reset; only slots behind the pointers are read.
  always_ff @(posedge traffic_clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign head  = mem[rd_ptr];
  assign count = cnt;

endmodule

// File: rtl/fr_car_queue.sv
// Farm-road vehicle queue: occupancy, head-car wait time,
// long-wait request and served/dropped statistics.
module fr_car_queue #(
  parameter int QUEUE_DEPTH = traffic_pkg::QUEUE_DEPTH,
  parameter int TS_W        = traffic_pkg::TS_W,
  parameter int WAIT_LIMIT  = traffic_pkg::WAIT_LIMIT,
  parameter int SERVED_W    = traffic_pkg::SERVED_W
) (
  input logic           traffic_clk,
  input logic           reset,
  fr_car_queue_if.slave q
);
  import traffic_pkg::*;

  logic [TS_W-1:0]     ts_now;
  logic [TS_W-1:0]     head_ts;
  logic [TS_W-1:0]     wait_v;
  logic [SERVED_W-1:0] served;
  count_t              cnt;
  logic                empty;
  logic                full;
  logic                push;
  logic                pop;
  logic                ovf;
  logic                unf;

  assign empty = (cnt == 5'd0);
  assign full  = (cnt == 5'(QUEUE_DEPTH));

  // A full queue still accepts an arrival when a car leaves.
  assign pop  = q.car_depart && !empty;
  assign push = q.car_arrive && (!full || q.car_depart);

  ts_fifo #(
    .DEPTH (QUEUE_DEPTH),
    .W     (TS_W)
  ) u_fifo (
    .traffic_clk (traffic_clk),
    .reset       (reset),
    .push        (push),
    .pop         (pop),
    .wdata       (ts_now),
    .head        (head_ts),
    .count       (cnt)
  );

  always_ff @(posedge traffic_clk) begin
    if (reset) begin
      ts_now <= '0;
      served <= '0;
      ovf    <= 1'b0;
      unf    <= 1'b0;
    end else begin
      ts_now <= ts_now + TS_W'(1);
      if (pop) served <= served + SERVED_W'(1);
      if (q.car_arrive && full && !q.car_depart)
        ovf <= 1'b1;
      if (q.car_depart && empty)
        unf <= 1'b1;
    end
  end

  assign wait_v = empty ? '0 : (ts_now - head_ts);

  assign q.car_in_queue = !empty;
  assign q.car_count    = cnt;
  assign q.queue_full   = full;
  assign q.oldest_wait  = wait_v;
  assign q.long_wait    = !empty
                       && (32'(wait_v) >= 32'(WAIT_LIMIT));
  assign q.overflow     = ovf;
  assign q.underflow    = unf;
  assign q.cars_served  = served;

endmodule

// File: tb/tb_fr_car_queue.sv
// Directed bench for fr_car_queue: vector table plus
// hand-built fill, drain, wait and reset sequences.
module tb_fr_car_queue;
  import traffic_pkg::*;

  logic traffic_clk = 1'b0;
  logic reset       = 1'b1;

  fr_car_queue_if qif ();

  fr_car_queue dut (
    .traffic_clk (traffic_clk),
    .reset       (reset),
    .q           (qif)
  );

  always #5 traffic_clk = ~traffic_clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic a;
    logic d;
    int   cnt;
    int   wt;
    int   unf;
    int   srv;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag,
                         input int cnt, input int wt,
                         input int ovf, input int unf,
                         input int srv);
    chk({tag, ".count"}, 32'(qif.car_count), cnt);
    chk({tag, ".inq"}, 32'(qif.car_in_queue),
        (cnt != 0) ? 1 : 0);
    chk({tag, ".full"}, 32'(qif.queue_full),
        (cnt == QUEUE_DEPTH) ? 1 : 0);
    chk({tag, ".wait"}, 32'(qif.oldest_wait), wt);
    chk({tag, ".long"}, 32'(qif.long_wait),
        (cnt != 0 && wt >= WAIT_LIMIT) ? 1 : 0);
    chk({tag, ".ovf"}, 32'(qif.overflow), ovf);
    chk({tag, ".unf"}, 32'(qif.underflow), unf);
    chk({tag, ".served"}, 32'(qif.cars_served), srv);
  endtask

  task automatic step(input logic a, input logic d);
    qif.car_arrive = a;
    qif.car_depart = d;
    @(posedge traffic_clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    qif.car_arrive = 1'b0;
    qif.car_depart = 1'b0;
    reset = 1'b1;
    repeat (n) @(posedge traffic_clk);
    #1;
    reset = 1'b0;
    chk_all("reset", 0, 0, 0, 0, 0);
  endtask

  initial begin
    qif.car_arrive = 1'b0;
    qif.car_depart = 1'b0;

    // a, d, count, wait, underflow, served
    tbl[0]  = '{1'b0, 1'b0, 0, 0, 0, 0};
    tbl[1]  = '{1'b1, 1'b0, 1, 1, 0, 0};
    tbl[2]  = '{1'b0, 1'b0, 1, 2, 0, 0};
    tbl[3]  = '{1'b1, 1'b0, 2, 3, 0, 0};
    tbl[4]  = '{1'b1, 1'b1, 2, 2, 0, 1};
    tbl[5]  = '{1'b0, 1'b1, 1, 2, 0, 2};
    tbl[6]  = '{1'b0, 1'b1, 0, 0, 0, 3};
    tbl[7]  = '{1'b0, 1'b1, 0, 0, 1, 3};
    tbl[8]  = '{1'b1, 1'b1, 1, 1, 1, 3};
    tbl[9]  = '{1'b0, 1'b0, 1, 2, 1, 3};
    tbl[10] = '{1'b0, 1'b1, 0, 0, 1, 4};

    do_reset(4);
    for (int i = 0; i < 11; i++) begin
      step(tbl[i].a, tbl[i].d);
      chk_all($sformatf("vec%0d", i), tbl[i].cnt,
              tbl[i].wt, 0, tbl[i].unf, tbl[i].srv);
    end

    // Idle after reset, then one car at cycle 5.
    do_reset(4);
    for (int j = 0; j < 27; j++) begin
      step(j == 5, 1'b0);
      if (j < 5)
        chk_all($sformatf("idle%0d", j), 0, 0, 0, 0, 0);
      else
        chk_all($sformatf("single%0d", j), 1, j - 4,
                0, 0, 0);
    end

    // Underflow on empty, then arrive+depart on empty.
    do_reset(2);
    step(1'b0, 1'b1);
    chk_all("unf_dep", 0, 0, 0, 1, 0);
    step(1'b1, 1'b1);
    chk_all("unf_both", 1, 1, 0, 1, 0);

    // Fill, swap at full, drop, drain.
    do_reset(2);
    for (int k = 0; k < 15; k++) begin
      step(1'b1, 1'b0);
      chk_all($sformatf("fill%0d", k), k + 1, k + 1,
              0, 0, 0);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1);
      chk_all($sformatf("swap%0d", i), 15, 15,
              0, 0, i + 1);
    end
    step(1'b1, 1'b0);
    chk_all("drop", 15, 16, 1, 0, 3);
    for (int i = 0; i < 15; i++) begin
      step(1'b0, 1'b1);
      chk_all($sformatf("drain%0d", i), 14 - i,
              (i < 14) ? 16 : 0, 1, 0, 4 + i);
    end

    // Cars at relative 0, 4, 9; pop at 12.
    for (int r = 0; r < 13; r++) begin
      step(r == 0 || r == 4 || r == 9, r == 12);
      if (r == 9)
        chk_all("rel9", 3, 10, 1, 0, 18);
    end
    chk_all("rel12", 2, 9, 1, 0, 19);
    step(1'b0, 1'b0);
    reset = 1'b1;
    step(1'b0, 1'b0);
    reset = 1'b0;
    chk_all("midreset", 0, 0, 0, 0, 0);
    step(1'b1, 1'b0);
    chk_all("postreset", 1, 1, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule

// File: doc/fr_car_queue.md
Name: fr_car_queue

Overview:
Farm-road vehicle queue model with per-car arrival timestamps.
- Sits between the farm-road arrival generator (upstream, `car_arrive`) and the random farm-road release stage (downstream). The release stage consumes `car_in_queue` and returns its `add_Car` pulse here as `car_depart`.
- Tracks queue occupancy and the wait time of the oldest car.
- Raises a long-wait request to the light controller and keeps served/dropped statistics.

Parameters:
- QUEUE_DEPTH, 15, maximum cars held; power-of-two minus one not required; range 2..31.
- TS_W, 8, width of the free-running timestamp counter and of `oldest_wait`.
- WAIT_LIMIT, 20, `oldest_wait` value at or above which `long_wait` asserts.
- SERVED_W, 10, width of the served-car statistics counter.

Ports:
- traffic_clk  input  1  traffic clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high.
- car_arrive  input  1  one-cycle-per-car arrival request from the upstream generator.
- car_depart  input  1  one-cycle-per-car departure from the release stage (its `add_Car`).
- car_in_queue  output  1  `car_count != 0`; feeds the release stage.
- car_count  output  5  current occupancy, 0..QUEUE_DEPTH.
- queue_full  output  1  `car_count == QUEUE_DEPTH`.
- oldest_wait  output  TS_W  cycles the head car has waited; 0 when empty.
- long_wait  output  1  `car_in_queue && oldest_wait >= WAIT_LIMIT`.
- overflow  output  1  sticky: an arrival was dropped because the queue was full.
- underflow  output  1  sticky: a departure arrived while the queue was empty.
- cars_served  output  SERVED_W  total accepted departures; wraps modulo 2^SERVED_W.

Behaviour:
- Reset values:
  - `ts_now` = 0; FIFO read and write pointers = 0; `car_count` = 0.
  - `overflow` = 0, `underflow` = 0, `cars_served` = 0.
  - Consequently `car_in_queue` = 0, `queue_full` = 0, `oldest_wait` = 0, `long_wait` = 0.
  - Reset mid-operation discards all queued cars; the next cycle behaves exactly as after power-up.
- `ts_now` increments by 1 every non-reset cycle and wraps modulo 2^TS_W.
- Push: if `car_arrive` is high and the push is accepted, `ts_now` of that cycle is written at the write pointer.
- Pop: if `car_depart` is high and `car_count != 0`, the read pointer advances.
- Pointers wrap from QUEUE_DEPTH-1 to 0.
- Acceptance rules, with `car_count` sampled at the clock edge:
  - Empty, arrive only: push; count becomes 1.
  - Empty, depart only: ignored; `underflow` sets.
  - Empty, arrive and depart: push only; depart ignored; `underflow` sets.
  - Non-empty, not full, arrive and depart: push and pop; count unchanged.
  - Full, arrive only: dropped; `overflow` sets; count unchanged.
  - Full, arrive and depart: push and pop both accepted; no overflow.
  - Non-empty, depart only: pop; count decrements.
- `cars_served` increments on every accepted pop.
- Latency: all registered outputs reflect an event one cycle after the edge that accepted it. `car_in_queue`, `queue_full` and `long_wait` are combinational from registers only, so they carry no combinational path from `car_arrive`/`car_depart`.
- `oldest_wait` is computed as `(ts_now - head_ts)` modulo 2^TS_W, and is forced to 0 when empty.
  - A car pushed at `ts_now` = T shows `oldest_wait` = 1 on the following cycle.
  - Waits of 2^TS_W cycles or more alias. This is a documented limitation; the controller must service long waits before then.
- After a pop, `oldest_wait` reflects the new head's own timestamp on the next cycle. It does not restart from 0.
- `overflow` and `underflow` clear only on reset.

Decomposition:
- Shared package `traffic_pkg`: QUEUE_DEPTH, TS_W, WAIT_LIMIT and SERVED_W defaults; the `count_t` (5-bit) typedef; the `ts_t` (TS_W-bit) typedef. The release stage and the controller reuse these.
- One sub-module `ts_fifo`: synchronous FIFO of `ts_t`, depth QUEUE_DEPTH.
  - Ports: push, pop, wdata, head data, count.
  - Push and pop gating (the acceptance rules above) stays in `fr_car_queue`.

Test Plan:
- Reset hold for 4 cycles, then release with no traffic -> all outputs 0 for 10 cycles; `oldest_wait` stays 0.
- Single arrival at cycle 5 after reset -> `car_count` = 1 and `car_in_queue` = 1 at cycle 6; `oldest_wait` = 1 at cycle 6 and 20 at cycle 25; `long_wait` rises at cycle 25.
- 16 back-to-back arrivals with default depth -> `car_count` saturates at 15; `queue_full` = 1; `overflow` sets on the 16th arrival; `car_count` stays 15.
- Full queue, simultaneous arrive and depart for 3 cycles -> `car_count` stays 15; `overflow` stays 0; `cars_served` = 3.
- Empty queue, depart pulse, then arrive and depart together -> `underflow` = 1; `car_count` = 1; `cars_served` = 0.
- Push 3 cars at cycles 0, 4 and 9 (relative), then pop the first at cycle 12 -> at cycle 13 `oldest_wait` = 9 (head is now the car from cycle 4) and `car_count` = 2. Assert reset at cycle 14 -> at cycle 15 `car_count` = 0 and `overflow`/`underflow` = 0.
